// File: rtl/fetch_stage.sv
// Instruction fetch stage with integrated IF/ID register: PC, imem req/ack handshake,
// stall hold buffer and branch redirect. Optional FETCH_MISALIGN_TRAP_EN adds misalign_err / S_TRAP.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        misalign_err,
`endif
    output logic        valid_out
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_TRAP  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3
    } state_t;
`endif

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] drain_addr_reg, drain_addr_next;
    logic [31:0] hold_instr_reg, hold_instr_next;
    logic [31:0] hold_pc_reg, hold_pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pc_out_reg, pc_out_next;
    logic        valid_reg, valid_next;
    logic        err_reg, err_next;

    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pc;
    logic [31:0] target;
    logic        halted;
    logic        trap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            pc_reg         <= RESET_PC;
            drain_addr_reg <= RESET_PC;
            hold_instr_reg <= NOP_INSTR;
            hold_pc_reg    <= 32'h0;
            instr_reg      <= NOP_INSTR;
            pc_out_reg     <= 32'h0;
            valid_reg      <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            drain_addr_reg <= drain_addr_next;
            hold_instr_reg <= hold_instr_next;
            hold_pc_reg    <= hold_pc_next;
            instr_reg      <= instr_next;
            pc_out_reg     <= pc_out_next;
            valid_reg      <= valid_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        drain_addr_next = drain_addr_reg;
        hold_instr_next = hold_instr_reg;
        hold_pc_next    = hold_pc_reg;
        instr_next      = instr_reg;
        pc_out_next     = pc_out_reg;
        valid_next      = valid_reg;
        err_next        = err_reg;
        deliver         = 1'b0;
        deliver_instr   = imem_rdata;
        deliver_pc      = pc_reg;
        target          = branch_target & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
        halted          = (state_reg == S_TRAP);
        trap            = |branch_target[1:0];
`else
        halted          = 1'b0;
        trap            = 1'b0;
`endif

        // Redirect outranks stall and ack; the IF/ID contents are flushed either way.
        if (branch_taken && !halted) begin
            pc_next         = target;
            hold_instr_next = NOP_INSTR;
            instr_next      = NOP_INSTR;
            valid_next      = 1'b0;
            if (trap) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                state_next = S_TRAP;
                err_next   = 1'b1;
`endif
            end else begin
                case (state_reg)
                    S_WAIT: begin
                        if (!imem_ack) begin
                            drain_addr_next = pc_reg;
                            state_next      = S_DRAIN;
                        end else begin
                            state_next = S_WAIT;
                        end
                    end
                    S_DRAIN: state_next = imem_ack ? S_WAIT : S_DRAIN;
                    default: state_next = S_WAIT;
                endcase
            end
        end else begin
            case (state_reg)
                S_IDLE: state_next = S_WAIT;
                S_WAIT: begin
                    if (imem_ack) begin
                        if (stall) begin
                            hold_instr_next = imem_rdata;
                            hold_pc_next    = pc_reg;
                            state_next      = S_HOLD;
                        end else begin
                            deliver = 1'b1;
                            pc_next = pc_reg + 32'd4;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        deliver       = 1'b1;
                        deliver_instr = hold_instr_reg;
                        deliver_pc    = hold_pc_reg;
                        pc_next       = pc_reg + 32'd4;
                        state_next    = S_WAIT;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) state_next = S_WAIT;
                end
                default: state_next = state_reg;
            endcase

            if (!stall) begin
                if (deliver) begin
                    instr_next  = deliver_instr;
                    pc_out_next = deliver_pc;
                    valid_next  = 1'b1;
                end else begin
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                end
            end
        end

        // While draining, the killed request keeps its original address on the bus.
        imem_req  = (state_reg == S_WAIT) || (state_reg == S_DRAIN);
        imem_addr = (state_reg == S_DRAIN) ? drain_addr_reg : pc_reg;
    end

    assign instr_out = instr_reg;
    assign pc_out    = pc_out_reg;
    assign valid_out = valid_reg;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_err = err_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; a second instance with RESET_PC=32'hFFFFFFFC covers PC wrap.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;

    logic        imem_req, w_req;
    logic [31:0] imem_addr, w_addr;
    logic [31:0] instr_out, w_instr;
    logic [31:0] pc_out, w_pc_out;
    logic        valid_out, w_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_err, w_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_out(instr_out), .pc_out(pc_out),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign_err(misalign_err),
`endif
        .valid_out(valid_out)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_out(w_instr), .pc_out(w_pc_out),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign_err(w_err),
`endif
        .valid_out(w_valid)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in S_IDLE, 1 time unit after a rising edge.
    task automatic do_reset();
        rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
    endtask

    // One request: a cycle without ack, then a one-cycle ack carrying data.
    task automatic do_fetch(input logic [31:0] data);
        imem_ack = 1'b0; cyc();
        imem_ack = 1'b1; imem_rdata = data; cyc();
        imem_ack = 1'b0;
        $display("txn: fetched %h pc_out=%h valid=%b", instr_out, pc_out, valid_out);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        n_checks++; if (instr_out !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", instr_out, NOP); end
        n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc_out: got %h want 0", pc_out); end
`ifdef FETCH_MISALIGN_TRAP_EN
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", misalign_err); end
`endif
    endtask

    task automatic test_sequential();
        do_reset(); cyc();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL seq_req0: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
        do_fetch(32'h0305_2283);
        n_checks++; if (instr_out !== 32'h0305_2283 || pc_out !== 32'h0 || valid_out !== 1'b1) begin n_fail++; $display("FAIL seq_out0: got %h/%h/%b want 03052283/0/1", instr_out, pc_out, valid_out); end
        n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL seq_addr1: got %h want 4", imem_addr); end
        do_fetch(32'h0055_2023);
        n_checks++; if (instr_out !== 32'h0055_2023 || pc_out !== 32'h4 || valid_out !== 1'b1) begin n_fail++; $display("FAIL seq_out1: got %h/%h/%b want 00552023/4/1", instr_out, pc_out, valid_out); end
        n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL seq_addr2: got %h want 8", imem_addr); end
        do_fetch(32'h8023_0293);
        n_checks++; if (instr_out !== 32'h8023_0293 || pc_out !== 32'h8 || valid_out !== 1'b1) begin n_fail++; $display("FAIL seq_out2: got %h/%h/%b want 80230293/8/1", instr_out, pc_out, valid_out); end
        cyc();
        n_checks++; if (valid_out !== 1'b0 || instr_out !== NOP || pc_out !== 32'h8) begin n_fail++; $display("FAIL seq_bubble: got %h/%h/%b want 00000013/8/0", instr_out, pc_out, valid_out); end
    endtask

    task automatic test_stall();
        do_reset(); cyc();
        do_fetch(32'h0305_2283);
        // Back-to-back ack for pc=4 arrives while decode stalls.
        imem_ack = 1'b1; imem_rdata = 32'h0055_2023; stall = 1'b1; cyc();
        imem_ack = 1'b0;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req: got %b want 0", imem_req); end
        n_checks++; if (instr_out !== 32'h0305_2283 || pc_out !== 32'h0 || valid_out !== 1'b1) begin n_fail++; $display("FAIL stall_hold1: got %h/%h/%b want 03052283/0/1", instr_out, pc_out, valid_out); end
        cyc(); cyc();
        n_checks++; if (instr_out !== 32'h0305_2283 || pc_out !== 32'h0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_hold3: got %h/%h req=%b want 03052283/0/0", instr_out, pc_out, imem_req); end
        stall = 1'b0; cyc();
        n_checks++; if (instr_out !== 32'h0055_2023 || pc_out !== 32'h4 || valid_out !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %h/%h/%b want 00552023/4/1", instr_out, pc_out, valid_out); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_next_req: got %b/%h want 1/8", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_outstanding();
        do_reset(); cyc();
        do_fetch(32'h0305_2283);
        do_fetch(32'h0055_2023);
        cyc();
        branch_taken = 1'b1; branch_target = 32'h40; cyc();
        branch_taken = 1'b0;
        n_checks++; if (valid_out !== 1'b0 || instr_out !== NOP) begin n_fail++; $display("FAIL redir_flush: got %h/%b want 00000013/0", instr_out, valid_out); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL redir_drain_addr: got %b/%h want 1/8", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; cyc();
        imem_ack = 1'b0;
        n_checks++; if (valid_out !== 1'b0 || instr_out !== NOP) begin n_fail++; $display("FAIL redir_late_ack: got %h/%b want 00000013/0", instr_out, valid_out); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL redir_new_addr: got %b/%h want 1/40", imem_req, imem_addr); end
        do_fetch(32'h0000_0093);
        n_checks++; if (instr_out !== 32'h0000_0093 || pc_out !== 32'h40 || valid_out !== 1'b1) begin n_fail++; $display("FAIL redir_target_fetch: got %h/%h/%b want 00000093/40/1", instr_out, pc_out, valid_out); end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset(); cyc();
        do_fetch(32'h0305_2283);
        imem_ack = 1'b0; cyc();
        imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        branch_taken = 1'b1; branch_target = 32'h100; cyc();
        imem_ack = 1'b0; branch_taken = 1'b0;
        n_checks++; if (valid_out !== 1'b0 || instr_out !== NOP) begin n_fail++; $display("FAIL same_flush: got %h/%b want 00000013/0", instr_out, valid_out); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL same_addr: got %b/%h want 1/100", imem_req, imem_addr); end
        do_fetch(32'h0010_0113);
        n_checks++; if (instr_out !== 32'h0010_0113 || pc_out !== 32'h100 || valid_out !== 1'b1) begin n_fail++; $display("FAIL same_fetch: got %h/%h/%b want 00100113/100/1", instr_out, pc_out, valid_out); end
    endtask

    task automatic test_async_reset();
        do_reset(); cyc();
        do_fetch(32'h0305_2283);
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b0 || valid_out !== 1'b0) begin n_fail++; $display("FAIL async_req_valid: got %b/%b want 0/0", imem_req, valid_out); end
        n_checks++; if (instr_out !== NOP || pc_out !== 32'h0) begin n_fail++; $display("FAIL async_instr: got %h/%h want 00000013/0", instr_out, pc_out); end
        cyc();
        rst_n = 1'b1; cyc();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL async_restart: got %b/%h want 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        do_reset(); cyc();
        n_checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first: got %b/%h want 1/fffffffc", w_req, w_addr); end
        do_fetch(32'h0305_2283);
        n_checks++; if (w_instr !== 32'h0305_2283 || w_pc_out !== 32'hFFFF_FFFC || w_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_out: got %h/%h/%b want 03052283/fffffffc/1", w_instr, w_pc_out, w_valid); end
        n_checks++; if (w_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_second: got %h want 0", w_addr); end
    endtask

    task automatic test_misalign();
        do_reset();
        branch_taken = 1'b1; branch_target = 32'h42; cyc();
        branch_taken = 1'b0;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL mis_valid: got %b want 0", valid_out); end
`ifdef FETCH_MISALIGN_TRAP_EN
        n_checks++; if (misalign_err !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL mis_trap: got err=%b req=%b want 1/0", misalign_err, imem_req); end
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678; cyc();
        imem_ack = 1'b0; cyc();
        n_checks++; if (misalign_err !== 1'b1 || imem_req !== 1'b0 || valid_out !== 1'b0) begin n_fail++; $display("FAIL mis_sticky: got err=%b req=%b valid=%b want 1/0/0", misalign_err, imem_req, valid_out); end
`else
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL mis_align: got %b/%h want 1/40", imem_req, imem_addr); end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_outstanding();
        test_redirect_same_cycle();
        test_async_reset();
        test_wrap();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
